// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// controller state encoding, limb width and the signed-overflow rule.
package wide_add_sequencer_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operands share a sign but the result flips it.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// The shared 16-bit datapath adder reused limb by limb by the sequencer.
module sixteen_bitadder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {16'd0, c_in};

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract controller: ripples one 16-bit adder over
// WORDS limbs, least significant first, with a start/busy/done handshake.
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = LIMB_W * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic         c_in,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         overflow
);

    localparam int IDX_W = $clog2(WORDS) + 1;

    state_t                         state_r;
    state_t                         state_nxt_s;
    logic [WORDS-1:0][LIMB_W-1:0]   a_r;
    logic [WORDS-1:0][LIMB_W-1:0]   b_r;
    logic [WORDS-1:0][LIMB_W-1:0]   acc_r;
    logic [WORDS-1:0][LIMB_W-1:0]   acc_nxt_s;
    logic                           carry_r;
    logic [IDX_W-1:0]               idx_r;
    logic [LIMB_W-1:0]              a_limb_s;
    logic [LIMB_W-1:0]              b_limb_s;
    logic [LIMB_W-1:0]              add_sum_s;
    logic                           add_c_s;
    logic                           last_s;
    logic [W-1:0]                   sum_r;
    logic                           c_out_r;
    logic                           ovf_r;
    logic                           busy_r;
    logic                           done_r;

    sixteen_bitadder u_adder (
        .a     (a_limb_s),
        .b     (b_limb_s),
        .c_in  (carry_r),
        .sum   (add_sum_s),
        .c_out (add_c_s)
    );

    // Limb select for the adder inputs and accumulator image with the current limb merged in.
    always_comb begin
        a_limb_s  = {LIMB_W{1'b0}};
        b_limb_s  = {LIMB_W{1'b0}};
        acc_nxt_s = acc_r;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                a_limb_s     = a_r[i];
                b_limb_s     = b_r[i];
                acc_nxt_s[i] = add_sum_s;
            end else begin
                acc_nxt_s[i] = acc_r[i];
            end
        end
        last_s = (idx_r == IDX_W'(WORDS - 1));
    end

    // Controller next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand capture, limb ripple and result publication on the final limb.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            acc_r   <= {W{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            sum_r   <= {W{1'b0}};
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1; the supplied carry is ignored.
                        a_r     <= a;
                        b_r     <= b ^ {W{sub}};
                        carry_r <= sub ? 1'b1 : c_in;
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    acc_r   <= acc_nxt_s;
                    carry_r <= add_c_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        sum_r   <= acc_nxt_s;
                        c_out_r <= add_c_s;
                        ovf_r   <= signed_ovf(a_r[WORDS-1][LIMB_W-1], b_r[WORDS-1][LIMB_W-1],
                                              add_sum_s[LIMB_W-1]);
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign c_out    = c_out_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer at WORDS=4 and WORDS=1 against an
// arithmetic reference model plus hand-computed directed expectations.
module tb_wide_add_sequencer;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        v;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start [2];
    logic        in_sub   [2];
    logic        in_cin   [2];
    logic [63:0] in_a     [2];
    logic [63:0] in_b     [2];

    logic        busy0, done0, c0, ov0;
    logic [63:0] sum0;
    logic        busy1, done1, c1, ov1;
    logic [15:0] sum1;

    logic        dut_busy [2];
    logic        dut_done [2];
    logic        dut_c    [2];
    logic        dut_ov   [2];
    logic [63:0] dut_sum  [2];

    int   ph  [2];
    res_t pend[2];
    res_t pub [2];
    logic cmp_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .start(in_start[0]), .sub(in_sub[0]), .c_in(in_cin[0]),
        .a(in_a[0]), .b(in_b[0]), .busy(busy0), .done(done0), .sum(sum0),
        .c_out(c0), .overflow(ov0)
    );

    wide_add_sequencer #(.WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(in_start[1]), .sub(in_sub[1]), .c_in(in_cin[1]),
        .a(in_a[1][15:0]), .b(in_b[1][15:0]), .busy(busy1), .done(done1), .sum(sum1),
        .c_out(c1), .overflow(ov1)
    );

    always_comb begin
        dut_busy[0] = busy0; dut_done[0] = done0; dut_c[0] = c0; dut_ov[0] = ov0;
        dut_sum[0]  = sum0;
        dut_busy[1] = busy1; dut_done[1] = done1; dut_c[1] = c1; dut_ov[1] = ov1;
        dut_sum[1]  = {48'd0, sum1};
    end

    function automatic int wd(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Reference arithmetic: unsigned result/carry and true signed overflow at w bits.
    function automatic res_t calc(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub);
        res_t               r;
        logic [64:0]        one;
        logic [64:0]        mask;
        logic [64:0]        aa;
        logic [64:0]        bb;
        logic [64:0]        full;
        logic signed [66:0] sa;
        logic signed [66:0] sb;
        logic signed [66:0] rs;
        logic signed [66:0] lim;
        one  = 65'd1;
        mask = (one << w) - 65'd1;
        aa   = {1'b0, a} & mask;
        bb   = {1'b0, b} & mask;
        if (!sub) begin
            full = aa + bb + {64'd0, cin};
            r.c  = full[w];
        end else begin
            full = aa - bb;
            r.c  = (aa >= bb);
        end
        r.s = full[63:0] & mask[63:0];
        sa  = $signed({2'b00, aa});
        sb  = $signed({2'b00, bb});
        if (aa[w-1]) sa = sa - ($signed({2'b00, one}) <<< w);
        if (bb[w-1]) sb = sb - ($signed({2'b00, one}) <<< w);
        rs  = sub ? (sa - sb) : (sa + sb + $signed({66'd0, cin}));
        lim = $signed(67'd1) <<< (w - 1);
        r.v = (rs >= lim) || (rs < -lim);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Cycle-level model: one op accepted from idle, published after wd(d) run cycles.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                ph[d]  <= 0;
                pub[d] <= '0;
            end else if (ph[d] == 0) begin
                if (in_start[d]) begin
                    ph[d]   <= 1;
                    pend[d] <= calc(16 * wd(d), in_a[d], in_b[d], in_cin[d], in_sub[d]);
                end
            end else if (ph[d] < wd(d)) begin
                ph[d] <= ph[d] + 1;
            end else if (ph[d] == wd(d)) begin
                ph[d]  <= wd(d) + 1;
                pub[d] <= pend[d];
            end else begin
                ph[d] <= 0;
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy_w%0d", wd(d)), {63'd0, dut_busy[d]}, {63'd0, ph[d] != 0});
                chk($sformatf("done_w%0d", wd(d)), {63'd0, dut_done[d]}, {63'd0, ph[d] == wd(d) + 1});
                chk($sformatf("sum_w%0d", wd(d)), dut_sum[d], pub[d].s);
                chk($sformatf("cout_w%0d", wd(d)), {63'd0, dut_c[d]}, {63'd0, pub[d].c});
                chk($sformatf("ovf_w%0d", wd(d)), {63'd0, dut_ov[d]}, {63'd0, pub[d].v});
            end
        end
    end

    task automatic launch_wait(input int d, input logic [63:0] a, input logic [63:0] b,
                               input logic cin, input logic sub, input string nm,
                               output int n, output int nb);
        logic seen;
        @(negedge clk);
        in_a[d] = a; in_b[d] = b; in_cin[d] = cin; in_sub[d] = sub; in_start[d] = 1'b1;
        n = 0; nb = 0; seen = 1'b0;
        while (!seen && n < 16) begin
            @(negedge clk);
            in_start[d] = 1'b0;
            n++;
            if (dut_busy[d]) nb++;
            if (dut_done[d]) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, {63'd0, seen}, 64'd1);
    endtask

    task automatic run_op(input int d, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub, input logic [63:0] es,
                          input logic ec, input logic ev, input string nm);
        res_t m;
        int   n;
        int   nb;
        m = calc(16 * wd(d), a, b, cin, sub);
        chk({nm, "_model_sum"}, m.s, es);
        chk({nm, "_model_c"}, {63'd0, m.c}, {63'd0, ec});
        chk({nm, "_model_v"}, {63'd0, m.v}, {63'd0, ev});
        launch_wait(d, a, b, cin, sub, nm, n, nb);
        chk({nm, "_latency"}, 64'(n), 64'(wd(d) + 1));
        chk({nm, "_busy_cycles"}, 64'(nb), 64'(wd(d) + 1));
        chk({nm, "_sum"}, dut_sum[d], es);
        chk({nm, "_cout"}, {63'd0, dut_c[d]}, {63'd0, ec});
        chk({nm, "_ovf"}, {63'd0, dut_ov[d]}, {63'd0, ev});
    endtask

    initial begin
        int n;
        int nb;
        int nd;
        int cyc;
        int prevd;
        int lastd;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_start[d] = 1'b0; in_sub[d] = 1'b0; in_cin[d] = 1'b0;
            in_a[d] = 64'd0; in_b[d] = 64'd0;
        end
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy0}, 64'd0);
        chk("reset_done", {63'd0, done0}, 64'd0);
        chk("reset_sum", sum0, 64'd0);
        chk("reset_cout", {63'd0, c0}, 64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Directed vectors, WORDS=4
        run_op(0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, "t1_w4");
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, "t2_w4");
        run_op(0, 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "t3a_w4");
        run_op(0, 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, "t3b_w4");
        run_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "t4_w4");

        // Same vectors scaled to WORDS=1
        run_op(1, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, "t1_w1");
        run_op(1, 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, "t2_w1");
        run_op(1, 64'd5, 64'd7, 1'b0, 1'b1, 64'h0000_0000_0000_FFFE, 1'b0, 1'b0, "t3a_w1");
        run_op(1, 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, "t3b_w1");
        run_op(1, 64'h0000_0000_0000_7FFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0000_8000, 1'b0, 1'b1, "t4_w1");

        // Start re-pulsed mid-RUN is ignored
        @(negedge clk);
        in_a[0] = 64'd1; in_b[0] = 64'd2; in_cin[0] = 1'b0; in_sub[0] = 1'b0; in_start[0] = 1'b1;
        @(negedge clk);
        in_start[0] = 1'b0;
        @(negedge clk);
        in_a[0] = 64'd100; in_b[0] = 64'd200; in_start[0] = 1'b1;
        @(negedge clk);
        in_start[0] = 1'b0;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done0) nd++;
        end
        chk("t5_single_done", 64'(nd), 64'd1);
        chk("t5_first_result", sum0, 64'd3);

        // Start held high: one op every WORDS+2 cycles
        @(negedge clk);
        in_a[0] = 64'd10; in_b[0] = 64'd20; in_start[0] = 1'b1;
        cyc = 0; nd = 0; prevd = -1; lastd = -1;
        repeat (20) begin
            @(negedge clk);
            cyc++;
            if (done0) begin
                nd++;
                prevd = lastd;
                lastd = cyc;
            end
        end
        in_start[0] = 1'b0;
        chk("t5_b2b_count", 64'(nd), 64'd3);
        chk("t5_b2b_period", 64'(lastd - prevd), 64'd6);
        chk("t5_b2b_sum", sum0, 64'd30);
        repeat (8) @(negedge clk);

        // Reset in the second RUN cycle aborts the op
        @(negedge clk);
        in_a[0] = 64'h1234; in_b[0] = 64'h1111; in_start[0] = 1'b1;
        @(negedge clk);
        in_start[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", {63'd0, busy0}, 64'd0);
        chk("t6_done", {63'd0, done0}, 64'd0);
        chk("t6_sum", sum0, 64'd0);
        rst = 1'b0;
        run_op(0, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0,
               64'h0000_0001_FFFF_FFFF, 1'b0, 1'b0, "t6_after");

        // Random sweep on both widths, checked by the every-cycle model compare
        for (int k = 0; k < 24; k++) begin
            launch_wait(k % 2, {$urandom, $urandom}, {$urandom, $urandom},
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand", n, nb);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
